// File: rtl/jtframe_sdram_pkg.sv
// ----------------------------------------------------------------------------
// jtframe_sdram_pkg: shared types and widths for the BRAM SDRAM responder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package jtframe_sdram_pkg;

   localparam int SDRAM_AW   = 22;
   localparam int LAT_W      = 4;   // holds RD_LAT-1 for RD_LAT up to 15
   localparam int REF_IDLE_W = 16;
   localparam int REF_CYC_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_REF  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/jtframe_sdram_bram.sv
// ----------------------------------------------------------------------------
// jtframe_sdram_bram: 2^AW x 16 single-port RAM, byte enables, registered read. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module jtframe_sdram_bram #(
   parameter int AW = 16
)(
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [1:0]    be,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [0:(1<<AW)-1];

   // Read-first: rdata shows the pre-write contents on a write cycle
   always_ff @(posedge clk) begin
      if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
      rdata <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/jtframe_sdram_resp.sv
// ----------------------------------------------------------------------------
// jtframe_sdram_resp: BRAM-backed responder for the jtframe SDRAM ROM/download port.
// Option: define JTFRAME_SDRAM_REFRESH_EN to model refresh cycles. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module jtframe_sdram_resp
   import jtframe_sdram_pkg::*;
#(
   parameter int MEM_AW     = 16,
   parameter int RD_LAT     = 4,
   parameter int REF_PERIOD = 64,
   parameter int REF_CYC    = 6
)(
   input  logic                rst,
   input  logic                clk,
   input  logic                loop_rst,
   input  logic                downloading,
   input  logic                prog_we,
   input  logic [SDRAM_AW-1:0] prog_addr,
   input  logic [7:0]          prog_data,
   input  logic [1:0]          prog_mask,
   input  logic                sdram_req,
   input  logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                refresh_en,
   output logic                sdram_ack,
   output logic                data_rdy,
   output logic [31:0]         data_read
);

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

   state_t              state, next_state;
   logic [LAT_W-1:0]    lat_cnt;
   logic [MEM_AW-1:0]   rd_addr;
   logic [MEM_AW-1:0]   ram_addr;
   logic                ram_we;
   logic [1:0]          ram_be;
   logic [15:0]         ram_rdata;
   logic [15:0]         lo_word;
   logic                ctl_rst;
   logic                rd_last;
   logic                ref_due;
   logic                ref_done;
   logic                unused_addr_bits;

   assign ctl_rst = rst | loop_rst;
   assign rd_last = (state == ST_RD) && (lat_cnt == LAT_LAST);

   // Upper address bits alias onto the smaller memory
   assign unused_addr_bits = ^{sdram_addr[SDRAM_AW-1:MEM_AW], prog_addr[SDRAM_AW-1:MEM_AW]};

`ifdef JTFRAME_SDRAM_REFRESH_EN
   logic [REF_IDLE_W-1:0] idle_cnt;
   logic [REF_CYC_W-1:0]  ref_cnt;

   assign ref_due  = (idle_cnt == REF_IDLE_W'(REF_PERIOD));
   assign ref_done = (ref_cnt == REF_CYC_W'(REF_CYC - 1));

   // Saturates at REF_PERIOD so a pending refresh waits for the arbiter
   always_ff @(posedge clk) begin
      if (ctl_rst) begin
         idle_cnt <= '0;
      end else if (state == ST_IDLE && refresh_en && !sdram_req) begin
         if (!ref_due) idle_cnt <= idle_cnt + REF_IDLE_W'(1);
      end else begin
         idle_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (ctl_rst || state != ST_REF) ref_cnt <= '0;
      else                            ref_cnt <= ref_cnt + REF_CYC_W'(1);
   end
`else
   logic unused_refresh;

   assign unused_refresh = refresh_en;
   assign ref_due        = 1'b0;
   assign ref_done       = 1'b1;
`endif

   always_comb begin
      next_state = state;
      sdram_ack  = 1'b0;
      ram_addr   = sdram_addr[MEM_AW-1:0];
      ram_we     = 1'b0;
      ram_be     = 2'b00;
      case (state)
         ST_IDLE: begin
            if (downloading && prog_we)        next_state = ST_WR;
            else if (ref_due)                  next_state = ST_REF;
            else if (sdram_req && !downloading) next_state = ST_RD;
         end
         ST_WR: begin
            sdram_ack  = 1'b1;
            ram_addr   = prog_addr[MEM_AW-1:0];
            ram_we     = 1'b1;
            ram_be     = ~prog_mask;
            next_state = ST_IDLE;
         end
         ST_RD: begin
            // Low word was addressed in IDLE; the high word is addressed here
            sdram_ack = (lat_cnt == '0);
            ram_addr  = rd_addr + MEM_AW'(1);
            if (rd_last) next_state = ST_IDLE;
         end
         ST_REF: begin
            if (ref_done) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ctl_rst) begin
         state     <= ST_IDLE;
         lat_cnt   <= '0;
         rd_addr   <= '0;
         lo_word   <= '0;
         data_rdy  <= 1'b0;
         data_read <= '0;
      end else begin
         state    <= next_state;
         data_rdy <= rd_last;
         if (state == ST_RD) lat_cnt <= lat_cnt + LAT_W'(1);
         else                lat_cnt <= '0;
         if (state == ST_IDLE && next_state == ST_RD) rd_addr <= sdram_addr[MEM_AW-1:0];
         if (state == ST_RD && lat_cnt == '0) lo_word <= ram_rdata;
         if (rd_last) data_read <= {ram_rdata, lo_word};
      end
   end

   jtframe_sdram_bram #(
      .AW    (MEM_AW)
   ) u_bram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (ram_be),
      .wdata ({prog_data, prog_data}),
      .rdata (ram_rdata)
   );

endmodule

`default_nettype wire
